// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder computing {cy,out} = A + B + C, DIGIT_W bits per clock, LSB digit first.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request; accepted only while idle
//   A, B   - WIDTH-bit operands, latched on accept
//   C      - carry-in, latched on accept
//   busy   - high while an addition is running
//   done   - one-cycle pulse when out/cy carry a fresh result
//   out    - sum modulo 2^WIDTH, held until the next completion
//   cy     - carry-out (bit WIDTH of the sum)
//   ovf    - signed overflow, present only when SERIAL_ADDER_OVF_EN is defined
module serial_adder #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  if (WIDTH < 1 || DIGIT_W < 1 || WIDTH % DIGIT_W != 0) begin : g_bad_width
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT_W");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_n;
  logic [CW-1:0] cnt;
  logic carry, last, accept;
  logic [DIGIT_W:0] dsum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    accept  = state == IDLE && start;
    last    = state == RUN && cnt == LAST;
    state_n = accept ? RUN : last ? IDLE : state;
    busy    = state == RUN;
    dsum    = {1'b0, a_sh[DIGIT_W-1:0]} + {1'b0, b_sh[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, carry};
    // new digit enters at the top; after NDIG shifts the LSB digit sits at bit 0
    sum_n   = WIDTH'({dsum[DIGIT_W-1:0], sum_sh} >> DIGIT_W);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      out    <= '0;
      cy     <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        a_sh   <= A;
        b_sh   <= B;
        carry  <= C;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> DIGIT_W;
        b_sh   <= b_sh >> DIGIT_W;
        carry  <= dsum[DIGIT_W];
        cnt    <= cnt + 1'b1;
        sum_sh <= sum_n;
      end
      if (last) begin
        out <= sum_n;
        cy  <= dsum[DIGIT_W];
      end
    end
`ifdef SERIAL_ADDER_OVF_EN
  // on the last digit the operand MSBs sit at bit DIGIT_W-1; carry into the MSB is recovered from its sum bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (last) ovf <= dsum[DIGIT_W-1] ^ a_sh[DIGIT_W-1] ^ b_sh[DIGIT_W-1] ^ dsum[DIGIT_W];
`endif
endmodule
